serial_add_sub: RTL and testbench

- Bit-serial adder/subtractor that drives a single FULL_ADDER bit-slice, one bit per clock, LSB first.
- Holds the slice's carry-out in a flip-flop and feeds it back as the next cycle's carry-in.
- Shifts sum bits into a result register and reports carry-out and signed overflow.
- Low-area alternative to a DATA_WIDTH-bit ripple adder for the ALU path.

---
 rtl/serial_add_sub.sv | 194 +++++++++++++++++++
 tb/tb_serial_add_sub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor built around one full-adder slice.
// Operands are consumed one bit per clock, LSB first. The slice carry-out is
// registered and becomes the next cycle's carry-in. A DATA_WIDTH-bit operation
// takes DATA_WIDTH cycles in RUN, followed by one FIN cycle that pulses DONE.
//
// Ports:
//   CLK     in   rising-edge clock
//   RST     in   asynchronous active-high reset
//   START   in   operation request, sampled only in IDLE
//   SUB     in   0 = A+B, 1 = A-B (captured with START)
//   OP_A    in   operand A (captured with START)
//   OP_B    in   operand B (captured with START)
//   BUSY    out  high while bits are being processed
//   DONE    out  one-cycle completion pulse
//   RESULT  out  sum/difference, held until the next capture
//   CO      out  final carry-out of the MSB slice (SUB: 1 = no borrow)
//   OVF     out  signed overflow (carry into MSB XOR carry out of MSB)
//   ZERO    out  result-is-zero flag, present only with SERIAL_ADD_SUB_ZERO_FLAG_EN
//
// Optional feature macro: SERIAL_ADD_SUB_ZERO_FLAG_EN

module serial_add_sub #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SUB,
    input  logic [DATA_WIDTH-1:0] OP_A,
    input  logic [DATA_WIDTH-1:0] OP_B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  CO,
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    output logic                  OVF,
    output logic                  ZERO
`else
    output logic                  OVF
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] sa_q, sa_d;
    logic [DATA_WIDTH-1:0] sb_q, sb_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic                  co_q, co_d;
    logic                  ovf_q, ovf_d;

    logic capture;
    logic last_bit;

    // Full-adder bit-slice.
    logic fa_a, fa_b, fa_ci, fa_s, fa_co;

    assign fa_a  = sa_q[0];
    assign fa_b  = sb_q[0];
    assign fa_ci = carry_q;
    assign fa_s  = fa_a ^ fa_b ^ fa_ci;
    assign fa_co = (fa_a & fa_b) | (fa_ci & (fa_a ^ fa_b));

    assign capture  = (state_q == StIdle) && START;
    assign last_bit = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = StRun;
            StRun:   if (last_bit) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state_q)
            StRun:   BUSY = 1'b1;
            StFin:   DONE = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        if (capture) begin
            sa_d     = OP_A;
            // Subtraction as A + ~B + 1: the +1 enters as the initial carry.
            sb_d     = SUB ? ~OP_B : OP_B;
            carry_d  = SUB;
            cnt_d    = '0;
            result_d = '0;
            co_d     = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == StRun) begin
            result_d = {fa_s, result_q[DATA_WIDTH-1:1]};
            sa_d     = {1'b0, sa_q[DATA_WIDTH-1:1]};
            sb_d     = {1'b0, sb_q[DATA_WIDTH-1:1]};
            carry_d  = fa_co;
            cnt_d    = cnt_q + CNT_WIDTH'(1);
            if (last_bit) begin
                co_d  = fa_co;
                // Carry into the MSB slice is the current carry FF.
                ovf_d = fa_co ^ carry_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    assign RESULT = result_q;
    assign CO     = co_q;
    assign OVF    = ovf_q;

`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    // Zero detect is tracked serially: a sticky flag records any 1 sum bit.
    logic nz_q, nz_d;
    logic zero_q, zero_d;

    always_comb begin
        nz_d   = nz_q;
        zero_d = zero_q;
        if (capture) begin
            nz_d   = 1'b0;
            zero_d = 1'b0;
        end else if (state_q == StRun) begin
            nz_d = nz_q | fa_s;
            if (last_bit) begin
                zero_d = ~(nz_q | fa_s);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nz_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            nz_q   <= nz_d;
            zero_q <= zero_d;
        end
    end

    assign ZERO = zero_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (DATA_WIDTH = 32).
// A cycle-level behavioural model (plain arithmetic plus a cycles-since-capture
// count) predicts every output; a compare process checks it on each negedge.
// Directed tests add literal expectations for latency and results.

module tb_serial_add_sub;

    localparam int DW = 32;

    logic          CLK   = 1'b0;
    logic          RST   = 1'b0;
    logic          START = 1'b0;
    logic          SUB   = 1'b0;
    logic [DW-1:0] OP_A  = '0;
    logic [DW-1:0] OP_B  = '0;
    logic          BUSY, DONE, CO, OVF;
    logic [DW-1:0] RESULT;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    logic          ZERO;
`endif

    serial_add_sub #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (6)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SUB    (SUB),
        .OP_A   (OP_A),
        .OP_B   (OP_B),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .CO     (CO),
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
        .OVF    (OVF),
        .ZERO   (ZERO)
`else
        .OVF    (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // {ovf, carry-out, result} of a (+/-) b modulo 2^DW.
    function automatic logic [DW+1:0] calc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic s);
        logic [DW-1:0] bb;
        logic [DW:0]   full;
        logic          ovf;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, s};
        ovf  = (a[DW-1] == bb[DW-1]) && (full[DW-1] != a[DW-1]);
        return {ovf, full};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model. k = 0 idle, 1..DW processing, DW+1 completion cycle.
    // ------------------------------------------------------------------
    int            k      = 0;
    logic [DW+1:0] p_pack = '0;
    logic [DW-1:0] m_res  = '0;
    logic          m_co   = 1'b0;
    logic          m_ovf  = 1'b0;
    logic          m_zero = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            k      <= 0;
            m_res  <= '0;
            m_co   <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b0;
        end else if (k == 0) begin
            if (START) begin
                p_pack <= calc(OP_A, OP_B, SUB);
                m_res  <= '0;
                m_co   <= 1'b0;
                m_ovf  <= 1'b0;
                m_zero <= 1'b0;
                k      <= 1;
            end
        end else if (k == DW) begin
            m_res  <= p_pack[DW-1:0];
            m_co   <= p_pack[DW];
            m_ovf  <= p_pack[DW+1];
            m_zero <= (p_pack[DW-1:0] == '0);
            k      <= DW + 1;
        end else if (k == DW + 1) begin
            k <= 0;
        end else begin
            k <= k + 1;
        end
    end

    // Compare process.
    always @(negedge CLK) begin
        chk("busy", {63'd0, BUSY}, {63'd0, (k >= 1 && k <= DW)});
        chk("done", {63'd0, DONE}, {63'd0, (k == DW + 1)});
        chk("co",   {63'd0, CO},   {63'd0, m_co});
        chk("ovf",  {63'd0, OVF},  {63'd0, m_ovf});
        if (!(k >= 1 && k <= DW)) chk("result", {32'd0, RESULT}, {32'd0, m_res});
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
        chk("zero", {63'd0, ZERO}, {63'd0, m_zero});
`endif
    end

    always @(posedge CLK) if (DONE) done_cnt++;

    function automatic logic [DW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                          input logic [DW-1:0] er, input logic eco, input logic eovf,
                          input logic ez, input string tag);
        int edges;
        int busy_cnt;
        @(negedge CLK);
        START = 1'b1; SUB = s; OP_A = a; OP_B = b;
        @(posedge CLK);
        edges = 0;
        busy_cnt = 0;
        while (edges < 100) begin
            @(negedge CLK);
            START = 1'b0; OP_A = $urandom; OP_B = $urandom; SUB = 1'($urandom);
            if (DONE) break;
            if (BUSY) busy_cnt++;
            @(posedge CLK);
            edges++;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(DW));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(DW));
        chk({tag, "_result"}, {32'd0, RESULT}, {32'd0, er});
        chk({tag, "_co"}, {63'd0, CO}, {63'd0, eco});
        chk({tag, "_ovf"}, {63'd0, OVF}, {63'd0, eovf});
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
        chk({tag, "_zero"}, {63'd0, ZERO}, {63'd0, ez});
`else
        if (ez === 1'bx) chk({tag, "_zero_arg"}, 64'd0, 64'd1);
`endif
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (DONE) break;
            n++;
        end
        if (n >= 100) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int d0;
        int gap;

        #1 RST = 1'b1;
        #2;
        chk("rst_busy",   {63'd0, BUSY}, 64'd0);
        chk("rst_done",   {63'd0, DONE}, 64'd0);
        chk("rst_result", {32'd0, RESULT}, 64'd0);
        chk("rst_co_ovf", {62'd0, CO, OVF}, 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Pin the reference arithmetic itself.
        chk("model_add",  {30'd0, calc(32'h5, 32'h7, 1'b0)}, {30'd0, 2'b00, 32'h0000_000C});
        chk("model_sub",  {30'd0, calc(32'h8000_0000, 32'h1, 1'b1)},
            {30'd0, 2'b11, 32'h7FFF_FFFF});
        chk("model_ovf",  {30'd0, calc(32'h7FFF_FFFF, 32'h1, 1'b0)},
            {30'd0, 2'b10, 32'h8000_0000});

        run_op(32'h5, 32'h7, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 1'b0, "add");
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "wrap");
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "sovf");
        run_op(32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub");
        run_op(32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "subovf");

        // START pulsed mid-RUN is ignored.
        @(negedge CLK);
        START = 1'b1; SUB = 1'b0; OP_A = 32'h1234_5678; OP_B = 32'h1111_1111;
        @(posedge CLK);
        d0 = done_cnt;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        START = 1'b1; OP_A = 32'hDEAD_BEEF; OP_B = 32'h0BAD_F00D; SUB = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (30) @(negedge CLK);
        chk("ignore_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("ignore_result", {32'd0, RESULT}, {32'd0, 32'h2345_6789});

        // Asynchronous reset mid-RUN.
        @(negedge CLK);
        START = 1'b1; SUB = 1'b0; OP_A = 32'hFFFF_0000; OP_B = 32'h0000_FFFF;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (14) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("arst_busy",   {63'd0, BUSY}, 64'd0);
        chk("arst_done",   {63'd0, DONE}, 64'd0);
        chk("arst_result", {32'd0, RESULT}, 64'd0);
        chk("arst_co_ovf", {62'd0, CO, OVF}, 64'd0);
        d0 = done_cnt;
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(32'h0000_1000, 32'h0000_0234, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, "post_rst");

        // START held high: back-to-back throughput.
        @(negedge CLK);
        START = 1'b1; SUB = 1'b1; OP_A = 32'd100; OP_B = 32'd1;
        wait_done("b2b_first");
        chk("b2b_first_result", {32'd0, RESULT}, {32'd0, 32'd99});
        OP_A = 32'h0F0F_0F0F; OP_B = 32'hF0F0_F0F0; SUB = 1'b0;
        gap = 0;
        while (gap < 100) begin
            @(negedge CLK);
            gap++;
            if (DONE) break;
        end
        START = 1'b0;
        chk("b2b_period", 64'(gap), 64'(DW + 2));
        chk("b2b_second_result", {32'd0, RESULT}, {32'd0, 32'hFFFF_FFFF});

        // Randomized operations, checked by the model.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            @(negedge CLK);
            START = 1'b1; SUB = 1'($urandom); OP_A = pick(); OP_B = pick();
            @(negedge CLK);
            START = 1'b0; OP_A = $urandom; OP_B = $urandom;
            wait_done("rand");
        end

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
